ysyx_25040129_mem_arb: RTL

Two-master, one-slave AXI arbiter between the instruction cache's miss/refill port and the LSU's data port, feeding the single downstream memory bus (crossbar/SoC side). Round-robin arbitration on whole transactions; a grant is held from address handshake until the final response beat. The ICACHE master is read-only with INCR bursts. The LSU master issues single-beat reads and writes.

---
 rtl/ysyx_25040129_pkg.sv | 24 ++
 rtl/ysyx_25040129_rr_pick2.sv | 36 +++
 rtl/ysyx_25040129_mem_arb.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_pkg.sv
// Shared types for the ysyx_25040129 memory arbiter.
// Holds the arbiter FSM state encoding, the master identifiers and the
// AXI burst/response constants. There are no ports.
package ysyx_25040129_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IC_AR = 3'd1,
    S_IC_R  = 3'd2,
    S_LS_AR = 3'd3,
    S_LS_R  = 3'd4,
    S_LS_W  = 3'd5,
    S_LS_B  = 3'd6
  } state_e;

  typedef enum logic {
    M_IC = 1'b0,
    M_LS = 1'b1
  } master_e;

  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/ysyx_25040129_rr_pick2.sv
// Two-requester round-robin picker: combinational pick plus registered last grant.
// Ports: clk_i/rst_i; req_ic_i/req_ls_i requests; upd_i commits the pick;
//        gnt_vld_o any request present; gnt_o chosen master.
module ysyx_25040129_rr_pick2
  import ysyx_25040129_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    req_ic_i,
  input  logic    req_ls_i,
  input  logic    upd_i,
  output logic    gnt_vld_o,
  output master_e gnt_o
);

  master_e last_q;
  master_e last_d;

  always_comb begin
    gnt_vld_o = req_ic_i | req_ls_i;
    if (req_ic_i && req_ls_i) begin
      // Contention: the master that did not win last time goes now.
      gnt_o = (last_q == M_IC) ? M_LS : M_IC;
    end else begin
      gnt_o = req_ls_i ? M_LS : M_IC;
    end
    last_d = (upd_i && gnt_vld_o) ? gnt_o : last_q;
  end

  // Reset value ICACHE means the LSU wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= M_IC;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/ysyx_25040129_mem_arb.sv
// Two-master (ICACHE read-only, LSU read/write) to one-slave AXI arbiter.
// Ports: ic_* ICACHE AR/R; lsu_* LSU AR/R/AW/W/B; mem_* downstream mirror.
// Whole transactions are granted round-robin; data paths are combinational.
module ysyx_25040129_mem_arb
  import ysyx_25040129_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  // ICACHE
  input  logic [31:0] ic_araddr_i,
  input  logic        ic_arvalid_i,
  input  logic [7:0]  ic_arlen_i,
  input  logic [1:0]  ic_arburst_i,
  output logic        ic_arready_o,
  output logic [31:0] ic_rdata_o,
  output logic [1:0]  ic_rresp_o,
  output logic        ic_rvalid_o,
  output logic        ic_rlast_o,
  input  logic        ic_rready_i,
  // LSU
  input  logic [31:0] lsu_araddr_i,
  input  logic        lsu_arvalid_i,
  output logic        lsu_arready_o,
  output logic [31:0] lsu_rdata_o,
  output logic [1:0]  lsu_rresp_o,
  output logic        lsu_rvalid_o,
  input  logic        lsu_rready_i,
  input  logic [31:0] lsu_awaddr_i,
  input  logic        lsu_awvalid_i,
  output logic        lsu_awready_o,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wstrb_i,
  input  logic        lsu_wvalid_i,
  output logic        lsu_wready_o,
  output logic [1:0]  lsu_bresp_o,
  output logic        lsu_bvalid_o,
  input  logic        lsu_bready_i,
  // Downstream memory bus
  output logic [31:0] mem_araddr_o,
  output logic        mem_arvalid_o,
  output logic [7:0]  mem_arlen_o,
  output logic [1:0]  mem_arburst_o,
  input  logic        mem_arready_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_rlast_i,
  output logic        mem_rready_o,
  output logic [31:0] mem_awaddr_o,
  output logic        mem_awvalid_o,
  output logic [7:0]  mem_awlen_o,
  output logic [1:0]  mem_awburst_o,
  input  logic        mem_awready_i,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_wvalid_o,
  output logic        mem_wlast_o,
  input  logic        mem_wready_i,
  input  logic [1:0]  mem_bresp_i,
  input  logic        mem_bvalid_i,
  output logic        mem_bready_o
);

  state_e  state_q;
  logic    aw_done_q;
  logic    w_done_q;
  logic    gnt_vld;
  master_e gnt;
  logic    ar_hs, r_hs, aw_hs, w_hs, b_hs;

  ysyx_25040129_rr_pick2 u_pick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_ic_i  (ic_arvalid_i),
    .req_ls_i  (lsu_arvalid_i | lsu_awvalid_i),
    .upd_i     (state_q == S_IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  assign ar_hs = mem_arvalid_o & mem_arready_i;
  assign r_hs  = mem_rvalid_i  & mem_rready_o;
  assign aw_hs = mem_awvalid_o & mem_awready_i;
  assign w_hs  = mem_wvalid_o  & mem_wready_i;
  assign b_hs  = mem_bvalid_i  & mem_bready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            if (gnt == M_LS) state_q <= lsu_awvalid_i ? S_LS_W : S_LS_AR;
            else             state_q <= S_IC_AR;
          end
        end
        S_IC_AR: if (ar_hs) state_q <= S_IC_R;
        S_IC_R:  if (r_hs && mem_rlast_i) state_q <= S_IDLE;
        S_LS_AR: if (ar_hs) state_q <= S_LS_R;
        // LSU reads are single-beat; rlast is not trusted here.
        S_LS_R:  if (r_hs) state_q <= S_IDLE;
        S_LS_W: begin
          // AW and W may complete in either order or in the same cycle.
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            state_q   <= S_LS_B;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_q | aw_hs;
            w_done_q  <= w_done_q | w_hs;
          end
        end
        S_LS_B:  if (b_hs) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write address/data payloads only ever come from the LSU.
  assign mem_awaddr_o  = lsu_awaddr_i;
  assign mem_awlen_o   = 8'd0;
  assign mem_awburst_o = INCR;
  assign mem_wdata_o   = lsu_wdata_i;
  assign mem_wstrb_o   = lsu_wstrb_i;
  assign mem_wlast_o   = 1'b1;

  always_comb begin
    mem_araddr_o  = lsu_araddr_i;
    mem_arlen_o   = 8'd0;
    mem_arburst_o = INCR;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    mem_awvalid_o = 1'b0;
    mem_wvalid_o  = 1'b0;
    mem_bready_o  = 1'b0;
    ic_arready_o  = 1'b0;
    ic_rdata_o    = 32'd0;
    ic_rresp_o    = OKAY;
    ic_rvalid_o   = 1'b0;
    ic_rlast_o    = 1'b0;
    lsu_arready_o = 1'b0;
    lsu_rdata_o   = 32'd0;
    lsu_rresp_o   = OKAY;
    lsu_rvalid_o  = 1'b0;
    lsu_awready_o = 1'b0;
    lsu_wready_o  = 1'b0;
    lsu_bresp_o   = OKAY;
    lsu_bvalid_o  = 1'b0;
    case (state_q)
      S_IC_AR: begin
        mem_araddr_o  = ic_araddr_i;
        mem_arlen_o   = ic_arlen_i;
        mem_arburst_o = ic_arburst_i;
        mem_arvalid_o = ic_arvalid_i;
        ic_arready_o  = mem_arready_i;
      end
      S_IC_R: begin
        ic_rdata_o   = mem_rdata_i;
        ic_rresp_o   = mem_rresp_i;
        ic_rvalid_o  = mem_rvalid_i;
        ic_rlast_o   = mem_rlast_i;
        mem_rready_o = ic_rready_i;
      end
      S_LS_AR: begin
        mem_arvalid_o = lsu_arvalid_i;
        lsu_arready_o = mem_arready_i;
      end
      S_LS_R: begin
        lsu_rdata_o  = mem_rdata_i;
        lsu_rresp_o  = mem_rresp_i;
        lsu_rvalid_o = mem_rvalid_i;
        mem_rready_o = lsu_rready_i;
      end
      S_LS_W: begin
        // Mask each channel once it has handshaken so it is never reissued.
        mem_awvalid_o = lsu_awvalid_i & ~aw_done_q;
        lsu_awready_o = mem_awready_i & ~aw_done_q;
        mem_wvalid_o  = lsu_wvalid_i & ~w_done_q;
        lsu_wready_o  = mem_wready_i & ~w_done_q;
      end
      S_LS_B: begin
        lsu_bresp_o  = mem_bresp_i;
        lsu_bvalid_o = mem_bvalid_i;
        mem_bready_o = lsu_bready_i;
      end
      default: ;
    endcase
  end

endmodule
